mips_id_stage: RTL and testbench

Parametrised MIPS instruction-decode stage: it decodes an instruction, reads two operands from an internal register file, and registers the result toward EX behind a valid/ready handshake. It owns the architectural register file: one write-back port, hardwired $zero, and same-cycle write-to-read bypass. A per-register pending scoreboard interlocks RAW and WAW hazards until write-back. It sits between instruction fetch and the ALU/EX stage and replaces the combinational s/t-register-only operand decoder.

---
 rtl/mips_id_stage.sv | 197 +++++++++++++++++++
 tb/tb_mips_id_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_id_stage.sv
// MIPS instruction-decode stage: decode, register-file read with write-back bypass,
// pending-write scoreboard interlock, and a registered valid/ready bundle toward EX.
module mips_id_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_store,
    output logic [4:0]        out_dest,
    output logic              out_mem_r,
    output logic              out_mem_w,
    output logic              out_reg_w,
    output logic              out_mem_to_reg,
    output logic [3:0]        out_alu_ctrl,
    output logic              out_illegal,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    typedef logic [DATA_W-1:0] word_t;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;
    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    logic       dec_mem_r, dec_mem_w, dec_reg_w, dec_mem_to_reg, dec_illegal;
    logic       rt_used, use_imm;
    logic [1:0] aluop;
    logic [3:0] dec_alu_ctrl;
    logic [4:0] dec_dest;

    always_comb begin
        dec_mem_r      = 1'b0;
        dec_mem_w      = 1'b0;
        dec_reg_w      = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_illegal    = 1'b0;
        rt_used        = 1'b0;
        use_imm        = 1'b0;
        aluop          = 2'b00;
        dec_dest       = 5'd0;
        unique case (opcode)
            6'h00: begin dec_reg_w = 1'b1; aluop = 2'b10; dec_dest = rd; rt_used = 1'b1; end
            6'h23: begin
                dec_mem_r = 1'b1; dec_reg_w = 1'b1; dec_mem_to_reg = 1'b1;
                dec_dest  = rt;   use_imm   = 1'b1;
            end
            6'h2B: begin dec_mem_w = 1'b1; use_imm = 1'b1; rt_used = 1'b1; end
            6'h04: begin aluop = 2'b01; rt_used = 1'b1; end
            6'h08: begin dec_reg_w = 1'b1; dec_dest = rt; use_imm = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase

        dec_alu_ctrl = 4'b0010;
        if (aluop == 2'b01) begin
            dec_alu_ctrl = 4'b0110;
        end else if (aluop == 2'b10) begin
            unique case (funct)
                6'h20: dec_alu_ctrl = 4'b0010;
                6'h22: dec_alu_ctrl = 4'b0110;
                6'h24: dec_alu_ctrl = 4'b0000;
                6'h25: dec_alu_ctrl = 4'b0001;
                6'h2A: dec_alu_ctrl = 4'b0111;
                default: begin dec_illegal = 1'b1; dec_reg_w = 1'b0; end
            endcase
        end
    end

    // Register file; entry 0 is never written and stays 0.
    word_t             regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic              out_valid_q;
    word_t             op1_q, op2_q, store_q;
    logic [4:0]        dest_q;
    logic              mem_r_q, mem_w_q, reg_w_q, mem_to_reg_q, illegal_q;
    logic [3:0]        alu_ctrl_q;

    logic  rs_in, rt_in, wb_in, dest_in;
    word_t rs_val, rt_val;
    assign rs_in   = 32'(rs) < NUM_REGS;
    assign rt_in   = 32'(rt) < NUM_REGS;
    assign wb_in   = 32'(wb_addr) < NUM_REGS;
    assign dest_in = 32'(dest_q) < NUM_REGS;

    // Out-of-range indices read 0 even when a write-back targets them.
    always_comb begin
        rs_val = '0;
        if (rs != 5'd0 && rs_in) begin
            if (wb_en && wb_addr == rs) rs_val = wb_data;
            else                        rs_val = regs_q[rs[IDX_W-1:0]];
        end
        rt_val = '0;
        if (rt != 5'd0 && rt_in) begin
            if (wb_en && wb_addr == rt) rt_val = wb_data;
            else                        rt_val = regs_q[rt[IDX_W-1:0]];
        end
    end

    function automatic logic busy(input logic [4:0] idx, input logic [NUM_REGS-1:0] pend,
                                  input logic clr_en, input logic [4:0] clr_addr,
                                  input logic held, input logic [4:0] held_dest);
        logic hit;
        hit = 1'b0;
        if (idx != 5'd0) begin
            if (32'(idx) < NUM_REGS && pend[idx[IDX_W-1:0]] && !(clr_en && clr_addr == idx))
                hit = 1'b1;
            if (held && held_dest == idx) hit = 1'b1;
        end
        return hit;
    endfunction

    logic held_w, hazard, accept, fire, set_en;
    assign held_w = out_valid_q && reg_w_q && !out_ready;
    assign hazard = !dec_illegal &&
                    (busy(rs, pending_q, wb_en, wb_addr, held_w, dest_q) ||
                     (rt_used && busy(rt, pending_q, wb_en, wb_addr, held_w, dest_q)) ||
                     busy(dec_dest, pending_q, wb_en, wb_addr, held_w, dest_q));
    assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_q && out_ready && !flush;
    assign set_en   = fire && reg_w_q && dest_q != 5'd0 && dest_in;

    // Set wins over a same-cycle write-back clear.
    always_comb begin
        pending_d = pending_q;
        if (wb_en && wb_in && wb_addr != 5'd0) pending_d[wb_addr[IDX_W-1:0]] = 1'b0;
        if (set_en) pending_d[dest_q[IDX_W-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (wb_en && wb_in && wb_addr != 5'd0) regs_q[wb_addr[IDX_W-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            store_q      <= '0;
            dest_q       <= '0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            reg_w_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_ctrl_q   <= '0;
            illegal_q    <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            op1_q        <= rs_val;
            op2_q        <= use_imm ? word_t'($signed(instr[15:0])) : rt_val;
            store_q      <= rt_val;
            dest_q       <= dec_dest;
            mem_r_q      <= dec_mem_r;
            mem_w_q      <= dec_mem_w;
            reg_w_q      <= dec_reg_w;
            mem_to_reg_q <= dec_mem_to_reg;
            alu_ctrl_q   <= dec_alu_ctrl;
            illegal_q    <= dec_illegal;
        end else if (flush || out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_op1        = op1_q;
    assign out_op2        = op2_q;
    assign out_store      = store_q;
    assign out_dest       = dest_q;
    assign out_mem_r      = mem_r_q;
    assign out_mem_w      = mem_w_q;
    assign out_reg_w      = reg_w_q;
    assign out_mem_to_reg = mem_to_reg_q;
    assign out_alu_ctrl   = alu_ctrl_q;
    assign out_illegal    = illegal_q;
endmodule

// File: tb/tb_mips_id_stage.sv
// Scoreboard bench for mips_id_stage: stimulus pushes expected bundles, a negedge
// monitor pops and compares them whenever EX consumes a bundle.
module tb_mips_id_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] instr;
    logic [31:0] out_op1, out_op2, out_store;
    logic [4:0]  out_dest;
    logic        out_mem_r, out_mem_w, out_reg_w, out_mem_to_reg, out_illegal;
    logic [3:0]  out_alu_ctrl;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        in_valid8, in_ready8, out_valid8, wb_en8;
    logic [31:0] instr8, op1_8, op2_8, store_8, wb_data8;
    logic [4:0]  dest_8, wb_addr8;
    logic        mr8, mw8, rw8, m2r8, ill8;
    logic [3:0]  alu8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_id_stage #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .out_op1(out_op1), .out_op2(out_op2), .out_store(out_store), .out_dest(out_dest),
        .out_mem_r(out_mem_r), .out_mem_w(out_mem_w), .out_reg_w(out_reg_w),
        .out_mem_to_reg(out_mem_to_reg), .out_alu_ctrl(out_alu_ctrl),
        .out_illegal(out_illegal), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    mips_id_stage #(.DATA_W(32), .NUM_REGS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .instr(instr8),
        .out_valid(out_valid8), .out_ready(1'b1), .flush(1'b0),
        .out_op1(op1_8), .out_op2(op2_8), .out_store(store_8), .out_dest(dest_8),
        .out_mem_r(mr8), .out_mem_w(mw8), .out_reg_w(rw8), .out_mem_to_reg(m2r8),
        .out_alu_ctrl(alu8), .out_illegal(ill8),
        .wb_en(wb_en8), .wb_addr(wb_addr8), .wb_data(wb_data8)
    );

    typedef struct {
        string       name;
        logic [31:0] op1, op2, store;
        logic [4:0]  dest;
        logic        mem_r, mem_w, reg_w, m2r;
        logic [3:0]  alu;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input string name, input logic [31:0] op1, op2, store,
                                input logic [4:0] dest, input logic mem_r, mem_w, reg_w, m2r,
                                input logic [3:0] alu, input logic ill);
        exp_t e;
        e.name = name; e.op1 = op1; e.op2 = op2; e.store = store; e.dest = dest;
        e.mem_r = mem_r; e.mem_w = mem_w; e.reg_w = reg_w; e.m2r = m2r;
        e.alu = alu; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_bundle: got dest %0d, required no bundle", out_dest);
            end else begin
                e = exp_q.pop_front();
                chk(e.name,
                    {out_op1, out_op2, out_store, out_dest, out_mem_r, out_mem_w, out_reg_w,
                     out_mem_to_reg, out_alu_ctrl, out_illegal},
                    {e.op1, e.op2, e.store, e.dest, e.mem_r, e.mem_w, e.reg_w, e.m2r,
                     e.alu, e.ill});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    // Present ins until accepted (bounded); returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] ins, input exp_t e, input bit push,
                         output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        instr    = ins;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (push) exp_q.push_back(e);
            end else begin
                waited++;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: got in_ready 0 for 8 cycles, required acceptance", e.name);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    int   w, total_w;
    exp_t nx;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        in_valid8 = 1'b0; instr8 = '0; wb_en8 = 1'b0; wb_addr8 = '0; wb_data8 = '0;
        nx = mk("none", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        #22 rst_n = 1'b1;
        tick();

        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_bundle", {out_op1, out_op2, out_store, out_dest, out_mem_r, out_mem_w,
                             out_reg_w, out_mem_to_reg, out_alu_ctrl, out_illegal}, '0);
        chk("reset_in_ready", in_ready, 1'b1);

        wb(5'd8, 32'd5);
        wb(5'd9, 32'd7);
        issue(32'h01095020, mk("add_t2", 5, 7, 7, 10, 0, 0, 1, 0, 4'b0010, 0), 1, w);
        chk("add_t2_wait", w, 0);
        issue(32'h8D0BFFFC, mk("lw_t3", 5, 32'hFFFFFFFC, 0, 11, 1, 0, 1, 1, 4'b0010, 0), 1, w);
        chk("lw_t3_wait", w, 0);
        tick();

        // RAW on $t3 stalls until its write-back, then accepts with the bypassed value.
        in_valid = 1'b1; instr = 32'h01686020;
        @(negedge clk); chk("raw_stall_0", in_ready, 1'b0);
        tick();
        @(negedge clk); chk("raw_stall_1", in_ready, 1'b0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h33;
        @(negedge clk); chk("raw_bypass_ready", in_ready, 1'b1);
        exp_q.push_back(mk("add_t4_bypass", 32'h33, 5, 5, 12, 0, 0, 1, 0, 4'b0010, 0));
        tick();
        in_valid = 1'b0; wb_en = 1'b0;

        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        issue(32'h00086822, mk("sub_zero_wb", 0, 5, 5, 13, 0, 0, 1, 0, 4'b0110, 0), 1, w);
        wb_en = 1'b0;
        chk("sub_wait", w, 0);
        issue(32'h01090020, mk("add_to_zero", 5, 7, 7, 0, 0, 0, 1, 0, 4'b0010, 0), 1, w);
        tick();
        issue(32'h00097024, mk("and_zero_rs", 0, 7, 7, 14, 0, 0, 1, 0, 4'b0000, 0), 1, w);
        chk("zero_never_pending", w, 0);

        total_w = 0;
        issue(32'h01097825, mk("or", 5, 7, 7, 15, 0, 0, 1, 0, 4'b0001, 0), 1, w);
        total_w += w;
        issue(32'h0128802A, mk("slt", 7, 5, 5, 16, 0, 0, 1, 0, 4'b0111, 0), 1, w);
        total_w += w;
        issue(32'hAD090008, mk("sw", 5, 8, 7, 0, 0, 1, 0, 0, 4'b0010, 0), 1, w);
        total_w += w;
        issue(32'h11090004, mk("beq", 5, 7, 7, 0, 0, 0, 0, 0, 4'b0110, 0), 1, w);
        total_w += w;
        issue(32'h2111FFFF, mk("addi", 5, 32'hFFFFFFFF, 0, 17, 0, 0, 1, 0, 4'b0010, 0), 1, w);
        total_w += w;
        issue(32'hFD400000, mk("illegal_op", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 1), 1, w);
        total_w += w;
        issue(32'h0109003F, mk("illegal_funct", 5, 7, 7, 0, 0, 0, 0, 0, 4'b0010, 1), 1, w);
        total_w += w;
        chk("back_to_back_waits", total_w, 0);

        // WAW on pending $t2; accepted when its write-back arrives (rt store bypassed).
        in_valid = 1'b1; instr = 32'h210A0001;
        @(negedge clk); chk("waw_stall", in_ready, 1'b0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h99;
        @(negedge clk); chk("waw_release", in_ready, 1'b1);
        exp_q.push_back(mk("addi_waw", 5, 1, 32'h99, 10, 0, 0, 1, 0, 4'b0010, 0));
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        tick();

        out_ready = 1'b0;
        issue(32'h01099820, mk("add_19_held", 5, 7, 7, 19, 0, 0, 1, 0, 4'b0010, 0), 1, w);
        in_valid = 1'b1; instr = 32'h0109A025;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_valid", out_valid, 1'b1);
            chk("held_in_ready", in_ready, 1'b0);
            chk("held_stable", {out_op1, out_dest}, {32'd5, 5'd19});
            tick();
        end
        out_ready = 1'b1;
        issue(32'h0109A025, nx, 0, w);
        chk("or20_wait", w, 0);
        out_ready = 1'b0;
        flush = 1'b1; in_valid = 1'b1; instr = 32'hFC000000;
        @(negedge clk); chk("flush_blocks_accept", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drops_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        issue(32'h0288A820, mk("add_21_after_flush", 0, 5, 5, 21, 0, 0, 1, 0, 4'b0010, 0), 1, w);
        chk("flushed_dest_not_pending", w, 0);
        tick();
        in_valid = 1'b1; instr = 32'h0268B020;
        @(negedge clk); chk("flush_keeps_pending", in_ready, 1'b0);
        tick();
        in_valid = 1'b0;

        out_ready = 1'b0;
        issue(32'h0109C825, nx, 0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 1'b0);
        chk("async_reset_dest", out_dest, 5'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        issue(32'h026AB820, mk("add_after_reset", 0, 0, 0, 23, 0, 0, 1, 0, 4'b0010, 0), 1, w);
        chk("no_stall_after_reset", w, 0);

        // NUM_REGS = 8: index 9 is out of range, must neither alias $1 nor read nonzero.
        wb_en8 = 1'b1; wb_addr8 = 5'd1; wb_data8 = 32'h55;
        tick();
        wb_addr8 = 5'd9; wb_data8 = 32'hAB;
        tick();
        wb_en8 = 1'b0; in_valid8 = 1'b1; instr8 = 32'h01211820;
        @(negedge clk); chk("r8_in_ready", in_ready8, 1'b1);
        tick();
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("r8_out_valid", out_valid8, 1'b1);
        chk("r8_rs9_reads_zero", {op1_8, op2_8, dest_8}, {32'd0, 32'h55, 5'd3});

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
